ps2_keymatrix: RTL and testbench

Parametrised PS/2 scancode decoder that owns the key-state matrix and a key-event queue for the CPU. It sits between `ps2in` and `cpu` and replaces the keyboard task and the `ps2in.ready`-clocked logic in the top level. All state runs on the CPU clock. It adds extended-code (E0) and Pause (E1) handling and typematic-repeat suppression. An optional event FIFO lets `Fx0A`-style waits see every press and release in order.

---
 rtl/ps2_keymatrix_pkg.sv | 36 +++
 rtl/ps2_keymatrix_if.sv | 23 ++
 rtl/ps2_keymatrix_fifo.sv | 42 ++++
 rtl/ps2_keymatrix.sv | 120 ++++++++++++
 tb/tb_ps2_keymatrix.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/ps2_keymatrix_pkg.sv
// ps2_keymatrix_pkg: parser states, PS/2 byte constants and the scancode-to-key lookup
package chip8_kbd_pkg;
  typedef enum logic [2:0] {P_IDLE, P_BRK, P_EXT, P_EXTBRK, P_SKIP} parse_state_e;
  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;
  function automatic logic [4:0] keymap_lookup(input logic ext, input logic [7:0] code);
    logic [4:0] r;
    r = '0;
    case ({ext, code})
      9'h016: r = {1'b1, 4'h1};
      9'h01E: r = {1'b1, 4'h2};
      9'h026: r = {1'b1, 4'h3};
      9'h025: r = {1'b1, 4'hC};
      9'h015: r = {1'b1, 4'h4};
      9'h01D: r = {1'b1, 4'h5};
      9'h024: r = {1'b1, 4'h6};
      9'h02D: r = {1'b1, 4'hD};
      9'h01C: r = {1'b1, 4'h7};
      9'h01B: r = {1'b1, 4'h8};
      9'h023: r = {1'b1, 4'h9};
      9'h02B: r = {1'b1, 4'hE};
      9'h01A: r = {1'b1, 4'hA};
      9'h022: r = {1'b1, 4'h0};
      9'h021: r = {1'b1, 4'hB};
      9'h02A: r = {1'b1, 4'hF};
      9'h175: r = {1'b1, 4'h5};
      9'h172: r = {1'b1, 4'h8};
      9'h16B: r = {1'b1, 4'h7};
      9'h174: r = {1'b1, 4'h9};
      default: r = '0;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/ps2_keymatrix_if.sv
// ps2_keymatrix_if: PS/2 byte input, key matrix and event queue signals of ps2_keymatrix
interface ps2_keymatrix_if #(
  parameter int NKEYS = 16,
  parameter int KW = (NKEYS > 1) ? $clog2(NKEYS) : 1
);
  logic             kbd_ready;
  logic [7:0]       kbd_data;
  logic [NKEYS-1:0] key_matrix;
  logic             ev_valid;
  logic [KW-1:0]    ev_key;
  logic             ev_down;
  logic             ev_ready;
  logic             overflow;
  logic             ovf_clr;
  modport master (
    output kbd_ready, kbd_data, ev_ready, ovf_clr,
    input  key_matrix, ev_valid, ev_key, ev_down, overflow
  );
  modport slave (
    input  kbd_ready, kbd_data, ev_ready, ovf_clr,
    output key_matrix, ev_valid, ev_key, ev_down, overflow
  );
endinterface

// File: rtl/ps2_keymatrix_fifo.sv
// kbd_event_fifo: show-ahead event FIFO that drops pushes when full and flags each drop
module kbd_event_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         res,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] dout_o,
  output logic         ovf_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic full, do_push, do_pop;
  assign valid_o = cnt_q != '0;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign do_pop = pop_i & valid_o;
  assign do_push = push_i & (~full | do_pop);
  assign ovf_o = push_i & full & ~do_pop;
  assign dout_o = valid_o ? mem_q[rd_q] : '0;
  // storage write; contents are masked at the output while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/ps2_keymatrix.sv
// ps2_keymatrix: PS/2 scancode parser owning the key matrix; event FIFO built when PS2_KEYMATRIX_FIFO_EN is defined
module ps2_keymatrix
  import chip8_kbd_pkg::*;
#(
  parameter int NKEYS = 16,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic res,
  ps2_keymatrix_if.slave bus
);
  localparam int KW = (NKEYS > 1) ? $clog2(NKEYS) : 1;
  localparam logic [2:0] S_IDLE = P_IDLE;
  localparam logic [2:0] S_BRK = P_BRK;
  localparam logic [2:0] S_EXT = P_EXT;
  localparam logic [2:0] S_EXTBRK = P_EXTBRK;
  localparam logic [2:0] S_SKIP = P_SKIP;
  logic [1:0] sync_q;
  logic rdy_q, stb, ign, key_ev, ext, down, hit, chg;
  logic [2:0] state_q, state_d, cnt_q, cnt_d;
  logic [NKEYS-1:0] mat_q, mat_d, sel;
  logic [15:0] sel16;
  logic [3:0] idx;
  logic [7:0] d;
  assign d = bus.kbd_data;
  assign stb = sync_q[1] & ~rdy_q;
  assign ign = d inside {8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF};
  // two-flop synchroniser for kbd_ready plus a delayed copy for rising-edge detection
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      sync_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], bus.kbd_ready};
      rdy_q <= sync_q[1];
    end
  end
  // parser: classify each strobed byte as prefix, make, break or skipped Pause byte
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    key_ev = 1'b0;
    ext = 1'b0;
    down = 1'b0;
    if (stb) begin
      case (state_q)
        S_IDLE: begin
          state_d = (d == PS2_BRK) ? S_BRK : (d == PS2_EXT) ? S_EXT : (d == PS2_PAUSE) ? S_SKIP : S_IDLE;
          cnt_d = (d == PS2_PAUSE) ? PAUSE_SKIP : cnt_q;
          key_ev = !(d inside {PS2_BRK, PS2_EXT, PS2_PAUSE}) && !ign;
          down = 1'b1;
        end
        S_BRK: begin
          state_d = S_IDLE;
          key_ev = 1'b1;
        end
        S_EXT: begin
          state_d = (d == PS2_BRK) ? S_EXTBRK : S_IDLE;
          key_ev = d != PS2_BRK;
          ext = 1'b1;
          down = 1'b1;
        end
        S_EXTBRK: begin
          state_d = S_IDLE;
          key_ev = 1'b1;
          ext = 1'b1;
        end
        S_SKIP: begin
          cnt_d = cnt_q - 3'd1;
          state_d = (cnt_q == 3'd1) ? S_IDLE : S_SKIP;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  assign {hit, idx} = keymap_lookup(ext, d);
  assign sel16 = 16'd1 << idx;
  assign sel = sel16[NKEYS-1:0];
  assign chg = key_ev && hit && (|sel) && ((|(mat_q & sel)) != down);
  assign mat_d = !chg ? mat_q : down ? (mat_q | sel) : (mat_q & ~sel);
  // parser state, Pause skip counter and key matrix
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      mat_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mat_q <= mat_d;
    end
  end
  assign bus.key_matrix = mat_q;
`ifdef PS2_KEYMATRIX_FIFO_EN
  logic ovf_stb, ovf_q;
  logic [KW:0] head;
  kbd_event_fifo #(.DEPTH(DEPTH), .W(KW + 1)) u_fifo (
    .clk(clk),
    .res(res),
    .push_i(chg),
    .din_i({idx[KW-1:0], down}),
    .pop_i(bus.ev_ready),
    .valid_o(bus.ev_valid),
    .dout_o(head),
    .ovf_o(ovf_stb)
  );
  assign {bus.ev_key, bus.ev_down} = head;
  // sticky overflow; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk or negedge res) begin
    if (!res) ovf_q <= 1'b0;
    else ovf_q <= ovf_stb | (ovf_q & ~bus.ovf_clr);
  end
  assign bus.overflow = ovf_q;
`else
  assign bus.ev_valid = 1'b0;
  assign bus.ev_key = '0;
  assign bus.ev_down = 1'b0;
  assign bus.overflow = 1'b0;
`endif
endmodule

// File: tb/tb_ps2_keymatrix.sv
// tb_ps2_keymatrix: directed and randomized scancode traffic checked against a key-action model
module tb_ps2_keymatrix;
  localparam int NKEYS = 16;
  localparam int DEPTH = 4;
`ifdef PS2_KEYMATRIX_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic res = 1'b0;
  always #5 clk = ~clk;
  ps2_keymatrix_if #(.NKEYS(NKEYS)) bus ();
  ps2_keymatrix #(.NKEYS(NKEYS), .DEPTH(DEPTH)) dut (.clk(clk), .res(res), .bus(bus));
  logic [7:0] ncode [16] = '{8'h22, 8'h16, 8'h1E, 8'h26, 8'h15, 8'h1D, 8'h24, 8'h1C,
                             8'h1B, 8'h23, 8'h1A, 8'h21, 8'h25, 8'h2D, 8'h2B, 8'h2A};
  logic [7:0] ecode [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
  int ekey [4] = '{5, 8, 7, 9};
  logic [7:0] ignb [5] = '{8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF};
  logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
  int km [512];
  logic [NKEYS-1:0] m_mat;
  logic [4:0] q[$];
  bit m_ovf;
  int checks = 0;
  int errors = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".matrix"}, 32'(bus.key_matrix), 32'(m_mat));
    chk({tag, ".ev_valid"}, 32'(bus.ev_valid), 32'(q.size() != 0));
    chk({tag, ".ev_key"}, 32'(bus.ev_key), (q.size() != 0) ? 32'(q[0][4:1]) : 0);
    chk({tag, ".ev_down"}, 32'(bus.ev_down), (q.size() != 0) ? 32'(q[0][0]) : 0);
    chk({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
  endtask
  task automatic model_key(input bit ext, input logic [7:0] code, input bit dn);
    int k;
    k = km[{ext, code}];
    if (k >= 0 && k < NKEYS && m_mat[k] != dn) begin
      m_mat[k] = dn;
      if (FIFO_EN) begin
        if (q.size() < DEPTH) q.push_back({4'(k), dn});
        else m_ovf = 1'b1;
      end
    end
  endtask
  task automatic model_reset();
    m_mat = '0;
    q.delete();
    m_ovf = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] b, input bit popsync);
    @(posedge clk);
    #1 bus.kbd_data = b;
    bus.kbd_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 if (popsync) bus.ev_ready = 1'b1;
    @(posedge clk);
    #1 bus.ev_ready = 1'b0;
    bus.kbd_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask
  task automatic key(input bit ext, input logic [7:0] code, input bit dn, input bit popsync);
    if (ext) send_byte(8'hE0, 1'b0);
    if (!dn) send_byte(8'hF0, 1'b0);
    send_byte(code, popsync);
    if (popsync && q.size() != 0) void'(q.pop_front());
    model_key(ext, code, dn);
  endtask
  task automatic pop_ev();
    @(posedge clk);
    #1 bus.ev_ready = 1'b1;
    @(posedge clk);
    #1 bus.ev_ready = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask
  task automatic drain(input string tag);
    int exp_n, n;
    exp_n = q.size();
    n = 0;
    for (int i = 0; i < DEPTH + 2 && bus.ev_valid; i++) begin
      check_all({tag, ".head"});
      pop_ev();
      n++;
    end
    chk({tag, ".count"}, 32'(n), 32'(exp_n));
    check_all({tag, ".empty"});
  endtask
  task automatic pulse_clr();
    @(posedge clk);
    #1 bus.ovf_clr = 1'b1;
    @(posedge clk);
    #1 bus.ovf_clr = 1'b0;
    m_ovf = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int r, k;
    bit dn;
    for (int i = 0; i < 512; i++) km[i] = -1;
    for (int i = 0; i < 16; i++) km[{1'b0, ncode[i]}] = i;
    for (int i = 0; i < 4; i++) km[{1'b1, ecode[i]}] = ekey[i];
    model_reset();
    bus.kbd_ready = 1'b0;
    bus.kbd_data = 8'h00;
    bus.ev_ready = 1'b0;
    bus.ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all("reset");
    res = 1'b1;
    // latency of a single make: visible at the third edge that sees kbd_ready high
    @(posedge clk);
    #1 bus.kbd_data = 8'h1C;
    bus.kbd_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 chk("lat.n1.bit7", 32'(bus.key_matrix[7]), 0);
    chk("lat.n1.ev_valid", 32'(bus.ev_valid), 0);
    @(posedge clk);
    #1 chk("lat.n2.bit7", 32'(bus.key_matrix[7]), 1);
    chk("lat.n2.ev_valid", 32'(bus.ev_valid), 32'(FIFO_EN));
    bus.kbd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 model_key(1'b0, 8'h1C, 1'b1);
    check_all("press7");
    key(1'b0, 8'h1C, 1'b0, 1'b0);
    check_all("release7");
    drain("press_release");
    // typematic repeats
    for (int i = 0; i < 3; i++) begin
      key(1'b0, 8'h16, 1'b1, 1'b0);
      check_all("typematic.make");
    end
    key(1'b0, 8'h16, 1'b0, 1'b0);
    check_all("typematic.break");
    drain("typematic");
    // extended code and Pause
    key(1'b1, 8'h75, 1'b1, 1'b0);
    check_all("ext.make");
    key(1'b1, 8'h75, 1'b0, 1'b0);
    check_all("ext.break");
    drain("ext");
    for (int i = 0; i < 8; i++) send_byte(pause_seq[i], 1'b0);
    check_all("pause");
    drain("pause");
    // overflow: five distinct makes with nothing popped
    key(1'b0, 8'h16, 1'b1, 1'b0);
    key(1'b0, 8'h1E, 1'b1, 1'b0);
    key(1'b0, 8'h26, 1'b1, 1'b0);
    key(1'b0, 8'h25, 1'b1, 1'b0);
    key(1'b0, 8'h15, 1'b1, 1'b0);
    check_all("overflow");
    pulse_clr();
    check_all("ovf_clr");
    // full FIFO: pop and push in the same cycle
    key(1'b0, 8'h1D, 1'b1, 1'b1);
    check_all("full_pop_push");
    drain("full_pop_push");
    // asynchronous reset in the middle of a break sequence
    send_byte(8'hF0, 1'b0);
    @(posedge clk);
    #3 res = 1'b0;
    #1 model_reset();
    check_all("mid_reset");
    @(posedge clk);
    #1 res = 1'b1;
    key(1'b0, 8'h1C, 1'b1, 1'b0);
    check_all("after_reset");
    // randomized traffic
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 9);
      dn = 1'($urandom_range(0, 1));
      if (r <= 5) begin
        k = $urandom_range(0, 19);
        if (k < 16) key(1'b0, ncode[k], dn, FIFO_EN && ($urandom_range(0, 3) == 0));
        else key(1'b1, ecode[k-16], dn, FIFO_EN && ($urandom_range(0, 3) == 0));
      end else if (r == 6) begin
        key(1'($urandom_range(0, 1)), 8'h70, dn, 1'b0);
      end else if (r == 7) begin
        pop_ev();
      end else if (r == 8) begin
        send_byte(ignb[$urandom_range(0, 4)], 1'b0);
      end else if (dn) begin
        for (int i = 0; i < 8; i++) send_byte(pause_seq[i], 1'b0);
      end else begin
        pulse_clr();
      end
      check_all("random");
    end
    drain("random_end");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
